uart_tx_byte: RTL and testbench

//  Byte-wide UART transmitter, 8N1 (optional 2 stop bits), LSB first, idle-high line.

---
 rtl/uart_tx_byte_pkg.sv | 27 ++
 rtl/uart_sync_fifo.sv | 74 +++++++
 rtl/uart_tx_byte.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_byte.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_byte_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_byte_pkg
//   Constants and encodings shared by the UART transmitter and its paired
//   byte receiver on the same serial link.
//   - uart_state_e   : line-level FSM states (IDLE/START/DATA/STOP)
//   - UART_FCLK_DEF  : default system clock frequency, Hz
//   - UART_BAUD_DEF  : default line rate, bit/s
//   - clks_per_bit() : integer clocks per serial bit for a clock/baud pair
// ---------------------------------------------------------------------------
package uart_tx_byte_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned UART_FCLK_DEF = 50_000_000;
  localparam int unsigned UART_BAUD_DEF = 115_200;

  function automatic int unsigned clks_per_bit(input int unsigned fclk,
                                               input int unsigned baud);
    return fclk / baud;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
//   Single-clock FIFO buffering bytes between the host handshake and the
//   serialiser.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     push, push_data : write request and data (ignored while full)
//     pop, pop_data   : read request; pop_data shows the head entry
//     full, empty     : occupancy flags
//     count           : entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module uart_sync_fifo
  import uart_tx_byte_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // The head entry must be visible in the same cycle as the pop so the
  // transmitter can load its shifter on the pop edge; the array is small
  // enough that an asynchronous read is the natural fit.
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    // DEPTH is a power of two, so pointers wrap by plain overflow.
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
//   Byte-wide UART transmitter, 8 data bits, no parity, 1 or 2 stop bits,
//   LSB first, idle-high line. Bytes enter through a valid/ready handshake
//   into a small FIFO and are serialised back-to-back at FCLK/BAUD clocks
//   per bit.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     tx_data    : byte to send, sampled on the push edge
//     tx_valid   : push request (push = tx_valid & tx_ready)
//     tx_ready   : FIFO not full
//     TXD        : serial line, straight from a flop
//     busy       : frame in progress or bytes waiting
//     fifo_count : bytes waiting, not counting the one in the shifter
// ---------------------------------------------------------------------------
module uart_tx_byte
  import uart_tx_byte_pkg::*;
#(
  parameter int unsigned FCLK       = UART_FCLK_DEF,
  parameter int unsigned BAUD       = UART_BAUD_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          TXD,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned NT = clks_per_bit(FCLK, BAUD);
  localparam int unsigned BW = $clog2(NT);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] CNT_LAST  = BW'(NT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  uart_state_e   state_q, state_d;
  logic [BW-1:0] cnt_q,   cnt_d;
  logic [2:0]    idx_q,   idx_d;   // data bit index in DATA, stop bit index in STOP
  logic [7:0]    shift_q, shift_d;
  logic          txd_q,   txd_d;
  logic          busy_q,  busy_d;

  logic          bit_end;
  logic          pop_req;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_cnt;
  logic          push_req;

  assign tx_ready   = ~fifo_full;
  assign push_req   = tx_valid & tx_ready;
  assign fifo_count = fifo_cnt;
  assign TXD        = txd_q;
  assign busy       = busy_q;

  uart_sync_fifo #(
    .W     (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (tx_data),
    .pop       (pop_req),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop_req = 1'b0;
    bit_end = (cnt_q == CNT_LAST);

    // The baud counter restarts on every bit boundary, which coincides with
    // every state entry out of START/DATA/STOP.
    if (state_q != ST_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + BW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_req = 1'b1;
          shift_d = fifo_rdata;
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = ST_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            // Chain straight into the next frame when a byte is waiting,
            // so back-to-back bytes have no idle gap on the line.
            if (!fifo_empty) begin
              pop_req = 1'b1;
              shift_d = fifo_rdata;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level follows the current state, registered one clock later so
    // the pin is driven only from a flop.
    txd_d = 1'b1;
    case (state_q)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_q[0];
      default:  txd_d = 1'b1;
    endcase

    busy_d = (state_q != ST_IDLE) | (fifo_cnt != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_byte.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_byte
//   Instance 0: default rate (434 clocks/bit, 1 stop bit).
//   Instance 1: 4 clocks/bit, 2 stop bits, also decoded by a bench receiver.
//   A frame-level model predicts TXD, busy, tx_ready and fifo_count every
//   cycle; directed tests add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_uart_tx_byte;

  logic       clk;
  logic       rst_n;
  logic [7:0] td  [2];
  logic       tv  [2];
  logic       rdy [2];
  logic       txd [2];
  logic       bsy [2];
  logic [2:0] cnt [2];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_byte dut0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (td[0]),
    .tx_valid   (tv[0]),
    .tx_ready   (rdy[0]),
    .TXD        (txd[0]),
    .busy       (bsy[0]),
    .fifo_count (cnt[0])
  );

  uart_tx_byte #(
    .FCLK       (4),
    .BAUD       (1),
    .FIFO_DEPTH (4),
    .STOP_BITS  (2)
  ) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_data    (td[1]),
    .tx_valid   (tv[1]),
    .tx_ready   (rdy[1]),
    .TXD        (txd[1]),
    .busy       (bsy[1]),
    .fifo_count (cnt[1])
  );

  task automatic chk(input string nm, input int inst, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s inst=%0d t=%0t got=%0h want=%0h", nm, inst, $time, got, want);
    end
  endtask

  // ---------------- frame-level model ----------------
  int         nt_m  [2] = '{434, 4};
  int         sb_m  [2] = '{1, 2};
  int         msize [2];
  int         mhead [2];
  int         mlast [2];
  bit         mhave [2];
  logic [7:0] mbuf  [2][8];
  logic [7:0] mbyte [2];
  logic       etxd  [2];
  logic       ebusy [2];
  logic       erdy  [2];
  int         ecnt  [2];
  int         mcyc;
  int         m_len, m_sz0, m_off, m_bn;
  bit         m_act, m_pop, m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcyc = 0;
      for (int i = 0; i < 2; i++) begin
        msize[i] = 0; mhead[i] = 0; mlast[i] = -1000000; mhave[i] = 0;
        etxd[i] = 1'b1; ebusy[i] = 1'b0; erdy[i] = 1'b1; ecnt[i] = 0;
      end
    end else begin
      mcyc++;
      for (int i = 0; i < 2; i++) begin
        m_len = (9 + sb_m[i]) * nt_m[i];
        m_sz0 = msize[i];
        // a frame is on the wire during the L edges starting at its pop edge
        m_act = mhave[i] && ((mcyc - 1) < mlast[i] + m_len);
        ebusy[i] = m_act || (m_sz0 != 0);
        m_acc = tv[i] && (m_sz0 != 4);
        m_pop = (m_sz0 > 0) && !(mhave[i] && (mcyc < mlast[i] + m_len));
        if (m_pop) begin
          mbyte[i] = mbuf[i][mhead[i]];
          mhead[i] = (mhead[i] + 1) % 8;
          msize[i] = msize[i] - 1;
          mlast[i] = mcyc;
          mhave[i] = 1;
        end
        if (m_acc) begin
          mbuf[i][(mhead[i] + msize[i]) % 8] = td[i];
          msize[i] = msize[i] + 1;
        end
        // line: start bit, 8 data bits LSB first, then stop bits
        m_off = mcyc - mlast[i] - 1;
        etxd[i] = 1'b1;
        if (mhave[i] && m_off >= 0 && m_off < m_len) begin
          m_bn = m_off / nt_m[i];
          if (m_bn == 0) etxd[i] = 1'b0;
          else if (m_bn <= 8) etxd[i] = mbyte[i][m_bn-1];
        end
        ecnt[i] = msize[i];
        erdy[i] = (msize[i] != 4);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk("txd", i, int'(txd[i]), int'(etxd[i]));
        chk("busy", i, int'(bsy[i]), int'(ebusy[i]));
        chk("tx_ready", i, int'(rdy[i]), int'(erdy[i]));
        chk("fifo_count", i, int'(cnt[i]), ecnt[i]);
      end
    end
  end

  // ---------------- receiver on instance 1 (4 clocks/bit, 2 stop) ----------------
  logic [7:0] rx_buf [512];
  int         rx_n = 0;

  initial begin : rx_proc
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (rst_n && txd[1] === 1'b0) begin
        repeat (2) @(negedge clk);
        chk("rx_start", 1, int'(txd[1]), 0);
        for (int k = 0; k < 8; k++) begin
          repeat (4) @(negedge clk);
          b[k] = txd[1];
        end
        repeat (4) @(negedge clk);
        chk("rx_stop", 1, int'(txd[1]), 1);
        if (rx_n < 512) rx_buf[rx_n] = b;
        rx_n++;
      end
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic push(input int i, input logic [7:0] d, output int ecyc);
    int n;
    n = 0;
    tv[i] = 1'b1;
    td[i] = d;
    while (!rdy[i] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) chk("push_timeout", i, 1, 0);
    @(negedge clk);
    ecyc = mcyc;
  endtask

  task automatic wait_low(input int i, input int budget, output int t);
    int n;
    n = 0;
    while (txd[i] !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("timeout_txd_low", i, 1, 0);
    t = mcyc;
  endtask

  task automatic wait_idle(input int i, input int budget, output int t);
    int n;
    n = 0;
    while (bsy[i] !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("timeout_busy_low", i, 1, 0);
    t = mcyc;
  endtask

  task automatic check_bits(input int i, input logic [9:0] pat, input string nm);
    for (int b = 0; b < 10; b++) begin
      repeat ((b == 0) ? nt_m[i] / 2 : nt_m[i]) @(negedge clk);
      chk(nm, i, int'(txd[i]), int'(pat[b]));
    end
  endtask

  initial begin : global_guard
    #3_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int k, t0, t1, n, base;
    logic [7:0] d;
    logic [7:0] sent [256];
    logic [9:0] pat;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin tv[i] = 1'b0; td[i] = 8'h00; end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_txd", i, int'(txd[i]), 1);
      chk("rst_busy", i, int'(bsy[i]), 0);
      chk("rst_ready", i, int'(rdy[i]), 1);
      chk("rst_count", i, int'(cnt[i]), 0);
    end

    // 1: single 0x55
    push(0, 8'h55, k);
    tv[0] = 1'b0;
    wait_low(0, 100, t0);
    chk("t1_latency", 0, t0 - k, 2);
    pat = {1'b1, 8'h55, 1'b0};
    check_bits(0, pat, "t1_bit");
    wait_idle(0, 1000, t1);
    chk("t1_busy_fall", 0, t1 - t0, 4340);
    $display("txn t1 byte=55 txd_fall=%0d busy_fall=%0d", t0, t1);

    // 2: back-to-back 0xA5, 0x3C
    push(0, 8'hA5, k);
    push(0, 8'h3C, k);
    tv[0] = 1'b0;
    wait_low(0, 100, t0);
    repeat (4340 + 217) @(negedge clk);
    chk("t2_no_gap", 0, int'(txd[0]), 0);
    wait_idle(0, 10000, t1);
    chk("t2_total", 0, t1 - t0, 8680);
    $display("txn t2 bytes=A5,3C low_to_idle=%0d", t1 - t0);

    // 3: overflow with tx_valid held
    for (int b = 1; b <= 6; b++) begin
      push(0, 8'(b), k);
      if (b == 5) begin
        chk("t3_ready_drop", 0, int'(rdy[0]), 0);
        chk("t3_count_full", 0, int'(cnt[0]), 4);
      end
    end
    tv[0] = 1'b0;
    wait_idle(0, 30000, t1);
    $display("txn t3 bytes=01..06 idle_at=%0d", t1);

    // 4: reset during DATA bit 3 of 0xFF
    push(0, 8'hFF, k);
    push(0, 8'h12, k);
    tv[0] = 1'b0;
    wait_low(0, 100, t0);
    repeat (434 * 4 + 200) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_txd_rst", 0, int'(txd[0]), 1);
    chk("t4_count_rst", 0, int'(cnt[0]), 0);
    chk("t4_busy_rst", 0, int'(bsy[0]), 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    push(0, 8'h81, k);
    tv[0] = 1'b0;
    wait_low(0, 100, t0);
    pat = {1'b1, 8'h81, 1'b0};
    check_bits(0, pat, "t4_bit");
    wait_idle(0, 1000, t1);
    $display("txn t4 reset_mid_frame then byte=81 done_at=%0d", t1);

    // 5: two stop bits, 4 clocks/bit, byte 0x00
    push(1, 8'h00, k);
    tv[1] = 1'b0;
    wait_low(1, 100, t0);
    n = 0;
    while (txd[1] === 1'b0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("t5_low_run", 1, n, 36);
    wait_idle(1, 100, t1);
    chk("t5_frame_len", 1, t1 - t0, 44);
    $display("txn t5 byte=00 low=%0d frame=%0d", n, t1 - t0);

    // 6: loopback of 256 random bytes through the bench receiver
    base = rx_n;
    for (int j = 0; j < 256; j++) begin
      d = 8'($urandom);
      sent[j] = d;
      push(1, d, k);
    end
    tv[1] = 1'b0;
    wait_idle(1, 2000, t1);
    repeat (8) @(negedge clk);
    chk("t6_rx_count", 1, rx_n - base, 256);
    for (int j = 0; j < 256; j++) begin
      if (base + j < 512) chk("t6_rx_byte", 1, int'(rx_buf[base + j]), int'(sent[j]));
    end
    $display("txn t6 loopback bytes=%0d", rx_n - base);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
